// File: rtl/hyperbus_trx_seq_pkg.sv
// Shared HyperBus sequencer types: FSM state encoding and fixed CA phase length.
package hyperbus_trx_seq_pkg;

    localparam int unsigned CaLen = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_LAT,
        ST_XFER,
        ST_CS_END,
        ST_RWR
    } trx_state_e;

endpackage

// File: rtl/hyperbus_trx_seq_cnt.sv
// Loadable down-counter with zero flag; holds the cycles remaining after the current one.
// Load has priority over decrement; decrement stops at zero.
module hyperbus_trx_seq_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             tx_clk_90,
    input  logic             rst_ni,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic [Width-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge tx_clk_90 or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/hyperbus_trx_seq.sv
// HyperBus transaction sequencer: CA, latency, data, CS-end and recovery phases.
// Outputs are decoded from state; req_ready_o is high only in IDLE, other requests are ignored.
module hyperbus_trx_seq
    import hyperbus_trx_seq_pkg::*;
#(
    parameter int unsigned NumChips = 2,
    parameter int unsigned CntWidth = 16
) (
    input  logic                        tx_clk_90,
    input  logic                        rst_ni,
    input  logic [3:0]                  cfg_latency_i,
    input  logic                        cfg_fixed_lat_i,
    input  logic [3:0]                  cfg_t_rwr_i,
    input  logic [CntWidth-1:0]         cfg_t_csm_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [$clog2(NumChips)-1:0] req_chip_i,
    input  logic                        req_write_i,
    input  logic [CntWidth-1:0]         req_len_i,
    input  logic                        rwds_sample_i,
    output logic [NumChips-1:0]         cs_o,
    output logic                        cs_ena_o,
    output logic                        tx_clk_ena_o,
    output logic                        tx_data_oe_o,
    output logic                        tx_rwds_oe_o,
    output logic                        rwds_sample_ena_o,
    output logic                        rx_clk_set_o,
    output logic                        rx_clk_reset_o,
    output logic                        ca_o,
    output logic                        word_ready_o,
    output logic                        done_o,
    output logic                        split_o,
    output logic [CntWidth-1:0]         rem_len_o
);

    localparam int unsigned ChipW = $clog2(NumChips);

    trx_state_e state_q, state_d;

    logic [ChipW-1:0]    chip_q;
    logic                write_q;
    logic [CntWidth-1:0] len_q;
    logic [3:0]          lat_q;
    logic                fixed_q;
    logic [3:0]          rwr_q;
    logic [CntWidth-1:0] csm_q;
    logic [CntWidth-1:0] csm_cnt_q;
    logic                lat_first_q;
    logic                split_q;
    logic [CntWidth-1:0] rem_q;

    logic                cnt_load;
    logic [CntWidth-1:0] cnt_load_val;
    logic                cnt_dec;
    logic [CntWidth-1:0] cnt;
    logic                cnt_zero;

    logic [CntWidth-1:0] lat_ext;
    logic [CntWidth-1:0] lat_m1;
    logic [CntWidth-1:0] lat2_m2;
    logic [CntWidth-1:0] len_m1;
    logic [CntWidth:0]   csm_next;
    logic                csm_hit;
    logic                lat_dbl;

    hyperbus_trx_seq_cnt #(
        .Width (CntWidth)
    ) u_cnt (
        .tx_clk_90 (tx_clk_90),
        .rst_ni    (rst_ni),
        .load      (cnt_load),
        .load_val  (cnt_load_val),
        .dec       (cnt_dec),
        .cnt       (cnt),
        .zero      (cnt_zero)
    );

    assign lat_ext  = CntWidth'(lat_q);
    assign lat_m1   = (lat_q == 4'd0) ? '0 : lat_ext - 1'b1;
    assign lat2_m2  = (lat_q == 4'd0) ? '0 : (lat_ext << 1) - CntWidth'(2);
    assign len_m1   = (len_q == '0) ? '0 : len_q - 1'b1;
    assign lat_dbl  = fixed_q | rwds_sample_i;
    // The word in flight is the last one allowed once the CS-low count reaches t_CSM-1.
    assign csm_next = {1'b0, csm_cnt_q} + {{CntWidth{1'b0}}, 1'b1};
    assign csm_hit  = (csm_next >= {1'b0, csm_q});

    always_comb begin
        state_d           = state_q;
        cnt_load          = 1'b0;
        cnt_load_val      = '0;
        cnt_dec           = 1'b0;
        req_ready_o       = 1'b0;
        cs_ena_o          = 1'b0;
        tx_clk_ena_o      = 1'b0;
        tx_data_oe_o      = 1'b0;
        tx_rwds_oe_o      = 1'b0;
        rwds_sample_ena_o = 1'b0;
        rx_clk_set_o      = 1'b0;
        rx_clk_reset_o    = 1'b0;
        ca_o              = 1'b0;
        word_ready_o      = 1'b0;
        done_o            = 1'b0;
        split_o           = 1'b0;
        rem_len_o         = '0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d      = ST_CA;
                    cnt_load     = 1'b1;
                    cnt_load_val = CntWidth'(CaLen - 1);
                end
            end
            ST_CA: begin
                cs_ena_o          = 1'b1;
                tx_clk_ena_o      = 1'b1;
                tx_data_oe_o      = 1'b1;
                ca_o              = 1'b1;
                rwds_sample_ena_o = 1'b1;
                cnt_dec           = 1'b1;
                if (cnt_zero) begin
                    state_d      = ST_LAT;
                    cnt_load     = 1'b1;
                    cnt_load_val = lat_m1;
                end
            end
            ST_LAT: begin
                cs_ena_o     = 1'b1;
                tx_clk_ena_o = 1'b1;
                if (lat_first_q && lat_dbl) begin
                    // Additional latency is decided once, in the first LAT cycle.
                    cnt_load     = 1'b1;
                    cnt_load_val = lat2_m2;
                end else if (cnt_zero) begin
                    rx_clk_set_o = !write_q;
                    state_d      = ST_XFER;
                    cnt_load     = 1'b1;
                    cnt_load_val = len_m1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_XFER: begin
                cs_ena_o     = 1'b1;
                tx_clk_ena_o = 1'b1;
                word_ready_o = 1'b1;
                tx_data_oe_o = write_q;
                tx_rwds_oe_o = write_q;
                cnt_dec      = 1'b1;
                if (cnt_zero || csm_hit) begin
                    state_d = ST_CS_END;
                end
            end
            ST_CS_END: begin
                cs_ena_o       = 1'b1;
                rx_clk_reset_o = !write_q;
                done_o         = 1'b1;
                split_o        = split_q;
                rem_len_o      = rem_q;
                // The IDLE cycle is itself a CS-high cycle, so RWR covers only the rest.
                if (rwr_q > 4'd1) begin
                    state_d      = ST_RWR;
                    cnt_load     = 1'b1;
                    cnt_load_val = CntWidth'(rwr_q) - CntWidth'(2);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RWR: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cs_o = cs_ena_o ? (NumChips'(1) << chip_q) : '0;

    always_ff @(posedge tx_clk_90 or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            chip_q      <= '0;
            write_q     <= 1'b0;
            len_q       <= '0;
            lat_q       <= '0;
            fixed_q     <= 1'b0;
            rwr_q       <= '0;
            csm_q       <= '0;
            csm_cnt_q   <= '0;
            lat_first_q <= 1'b0;
            split_q     <= 1'b0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            lat_first_q <= (state_q == ST_CA) && (state_d == ST_LAT);
            if (state_q == ST_IDLE && req_valid_i) begin
                chip_q  <= req_chip_i;
                write_q <= req_write_i;
                len_q   <= req_len_i;
                lat_q   <= cfg_latency_i;
                fixed_q <= cfg_fixed_lat_i;
                rwr_q   <= cfg_t_rwr_i;
                csm_q   <= cfg_t_csm_i;
            end
            if (state_q == ST_IDLE) begin
                csm_cnt_q <= '0;
                split_q   <= 1'b0;
                rem_q     <= '0;
            end else begin
                if (cs_ena_o && (csm_cnt_q != '1)) begin
                    csm_cnt_q <= csm_cnt_q + 1'b1;
                end
                if (state_q == ST_XFER && state_d == ST_CS_END) begin
                    split_q <= !cnt_zero;
                    rem_q   <= cnt_zero ? '0 : cnt;
                end
            end
        end
    end

endmodule
